// File: rtl/sar_ctrl.sv
// sar_ctrl: successive-approximation ADC sequencer (track, bit trials, done).
// Build with SAR_CTRL_SETTLE_EN to add a one-cycle DAC settle before each compare.
module sar_ctrl #(
  parameter int N             = 8,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         cmp,
  output logic         sample,
  output logic         cmp_en,
  output logic [N-1:0] dac_code,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         valid
);

  localparam int CW = $clog2(SAMPLE_CYCLES + 1);
  localparam int IW = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
`ifdef SAR_CTRL_SETTLE_EN
    S_SETTLE,
`endif
    S_COMPARE,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [N-1:0]   dac_q, dac_d;
  logic [N-1:0]   res_q, res_d;
  logic           valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      dac_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dac_q   <= dac_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dac_d   = dac_q;
    res_d   = res_q;
    valid_d = valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SAMPLE;
          cnt_d   = CW'(SAMPLE_CYCLES - 1);
          dac_d   = '0;
        end
      end
      S_SAMPLE: begin
        if (cnt_q == '0) begin
          idx_d        = IW'(N - 1);
          dac_d        = '0;
          dac_d[N-1]   = 1'b1;
`ifdef SAR_CTRL_SETTLE_EN
          state_d      = S_SETTLE;
`else
          state_d      = S_COMPARE;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef SAR_CTRL_SETTLE_EN
      S_SETTLE: begin
        state_d = S_COMPARE;
      end
`endif
      S_COMPARE: begin
        // cmp is only consulted here, so X outside COMPARE is harmless
        dac_d[idx_q] = cmp;
        if (idx_q != '0) begin
          dac_d[idx_q - 1'b1] = 1'b1;
          idx_d               = idx_q - 1'b1;
`ifdef SAR_CTRL_SETTLE_EN
          state_d             = S_SETTLE;
`else
          state_d             = S_COMPARE;
`endif
        end else begin
          state_d = S_DONE;
          res_d   = dac_d;
          valid_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign sample   = (state_q == S_SAMPLE);
  assign cmp_en   = (state_q == S_COMPARE);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign dac_code = dac_q;
  assign result   = res_q;
  assign valid    = valid_q;

endmodule

// File: doc/sar_ctrl.md
SAR_CTRL -- requirements
Module: sar_ctrl

Interface
REQ-001 Parameter N, default 8: conversion resolution in bits, legal range 2..12.
REQ-002 Parameter SAMPLE_CYCLES, default 2: length of the track phase in clock cycles, legal range 1..15.
REQ-003 clk  input  1  single clock; every register is updated on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 start  input  1  conversion request; sampled only in IDLE.
REQ-006 cmp  input  1  upstream comparator decision; 1 = input is at or above the DAC trial level.
REQ-007 sample  output  1  track enable to the front-end; high during SAMPLE.
REQ-008 cmp_en  output  1  comparator strobe; high during COMPARE.
REQ-009 dac_code  output  N  trial code driven to the feedback DAC.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse; result is updated in the same cycle.
REQ-012 result  output  N  last completed conversion; held until the next DONE.
REQ-013 valid  output  1  sticky; set at the first DONE, cleared only by reset.

Function
REQ-014 The FSM SHALL have states IDLE, SAMPLE, SETTLE (macro only), COMPARE and DONE, with the state held in a register.
REQ-015 Cycle numbering: cycle 0 is the cycle in which start=1 is sampled in IDLE.
REQ-016 From IDLE with start=1, the FSM SHALL go to SAMPLE; with start=0 it SHALL stay in IDLE.
REQ-017 SAMPLE SHALL last SAMPLE_CYCLES cycles, cycles 1..SAMPLE_CYCLES, using a down-counter; dac_code SHALL be 0 during SAMPLE.
REQ-018 On leaving SAMPLE, the bit index SHALL be set to N-1 and dac_code to 1 << (N-1).
REQ-019 In COMPARE, cmp SHALL be registered on the clock edge that ends the cycle.
- cmp=1: trial bit i is kept.
- cmp=0: trial bit i is cleared.
- Then, if i>0, bit i-1 is set and i is decremented.
REQ-020 The COMPARE decision for bit 0 SHALL transition to DONE; without SETTLE_EN, DONE occurs in cycle SAMPLE_CYCLES+N+1.
REQ-021 In DONE, done=1 and result equals the final code; next state SHALL be IDLE unconditionally.
REQ-022 start SHALL be ignored in every state other than IDLE, with no queuing.
- If start is held high continuously, a new conversion begins in the cycle after DONE.
REQ-023 Only the transition logic SHALL see cmp; X on cmp outside COMPARE SHALL NOT affect any output.
REQ-024 The bit index and counters SHALL be sized as ceil(log2) of their range; no wrap-around SHALL occur within legal parameters.

Reset
REQ-025 When rst=1 at a clock edge, the block SHALL enter IDLE regardless of state, aborting any conversion in progress.
REQ-026 Reset values: sample=0, cmp_en=0, dac_code=0, busy=0, done=0, result=0, valid=0, counters=0.
REQ-027 rst SHALL take priority over start when both are high in the same cycle.

Configuration
REQ-028 Macro SAR_CTRL_SETTLE_EN SHALL select whether a SETTLE state is compiled in.
- Defined: a one-cycle SETTLE state precedes every COMPARE, with cmp_en=0 and dac_code already updated.
- Defined: each bit takes 2 cycles and DONE occurs in cycle SAMPLE_CYCLES+2N+1.
- Not defined: no SETTLE state exists and COMPARE cycles run back to back.

Verification
REQ-029 Defaults, comparator model with input 0xA5 (cmp = input>=dac_code), start pulse -> done in cycle 11, result=0xA5, valid=1, dac_code sequence 80,C0,A0,B0,A8,A4,A6,A5 (hex).
REQ-030 Inputs 0x00 and 0xFF -> result 0x00 and 0xFF respectively, each with a single done pulse.
REQ-031 start re-pulsed in cycles 3 and 7 -> ignored; only one done pulse, in cycle 11.
REQ-032 rst=1 in cycle 5 mid-conversion -> cycle 6: busy=0, cmp_en=0, dac_code=0, result=0, valid=0; a following start converts normally.
REQ-033 start held high continuously -> done pulses in cycles 11 and 23, with busy=0 only in cycles 12 and 24.
REQ-034 SAR_CTRL_SETTLE_EN defined, input 0x3C -> done in cycle 19, result=0x3C, cmp_en high in alternate cycles 4,6,...,18.
